// File: rtl/ibis_dvi_timing_ctrl.sv
// ibis_dvi_timing_ctrl
// Raster timing generator for the DVI output. Produces the shared pixel strobe
// for the B/G/R TMDS encoders, the data-enable flag and the {vsync,hsync}
// control code. Pulls RGB pixels from a ready/valid source during active video.
module ibis_dvi_timing_ctrl #(
    parameter int PIX_DIV  = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        run,
    input  logic [23:0] s_pixel_data,
    input  logic        s_pixel_valid,
    output logic        s_pixel_ready,
    output logic        tmds_enable,
    output logic        tmds_data_enable,
    output logic [1:0]  tmds_control,
    output logic [7:0]  tmds_r,
    output logic [7:0]  tmds_g,
    output logic [7:0]  tmds_b,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic        frame_start,
    output logic        busy,
    output logic        underflow,
    input  logic        underflow_clear
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_raster_too_big
        $error("ibis_dvi_timing_ctrl: H_TOTAL and V_TOTAL must not exceed 4096");
    end
    if (PIX_DIV < 1) begin : g_bad_div
        $error("ibis_dvi_timing_ctrl: PIX_DIV must be at least 1");
    end

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    // 13-bit bounds so a total of exactly 4096 still compares correctly.
    localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
    localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_BEGIN = 13'(H_ACTIVE + H_FRONT);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [12:0] VS_BEGIN = 13'(V_ACTIVE + V_FRONT);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic       SYNC_ON  = (SYNC_POL != 0);
    localparam logic [1:0] CTL_IDLE = {~SYNC_ON, ~SYNC_ON};

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [11:0]      h_cnt, v_cnt;
    logic [11:0]      h_nxt, v_nxt;
    logic [11:0]      h_succ, v_succ;
    logic             frame_new;
    logic             pix_active_nxt;
    logic [1:0]       ctl_nxt;
    logic [23:0]      rgb_q;

    function automatic logic in_active(input logic [11:0] h, input logic [11:0] v);
        return ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
    endfunction

    function automatic logic [1:0] ctl_code(input logic [11:0] h, input logic [11:0] v);
        logic hs, vs;
        hs = ({1'b0, h} >= HS_BEGIN) && ({1'b0, h} < HS_END);
        vs = ({1'b0, v} >= VS_BEGIN) && ({1'b0, v} < VS_END);
        return {vs ? SYNC_ON : ~SYNC_ON, hs ? SYNC_ON : ~SYNC_ON};
    endfunction

    assign tick = (div_cnt == DIV_LAST);
    assign busy = (state == ST_RUN);

    // Source handshake: only on a strobe that is about to present an active pixel.
    assign s_pixel_ready = aresetn & tick & pix_active_nxt;

    assign {tmds_r, tmds_g, tmds_b} = rgb_q;

    // Scan state register; only moves on a pixel strobe.
    always_ff @(posedge aclk) begin
        // NOTE: every clocked assignment is non-blocking so all registers sample
        // pre-edge values and simulation order between blocks cannot matter.
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next scan position, frame sequencing and the look-ahead sync/active state.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        frame_new = 1'b0;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state_nxt = ST_RUN;
                        h_nxt     = '0;
                        v_nxt     = '0;
                        frame_new = 1'b1;
                    end
                end
                ST_RUN: begin
                    if ({1'b0, h_cnt} == H_LAST) begin
                        h_nxt = '0;
                        if ({1'b0, v_cnt} == V_LAST) begin
                            v_nxt = '0;
                            if (run) begin
                                frame_new = 1'b1;
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end else begin
                            v_nxt = v_cnt + 12'd1;
                        end
                    end else begin
                        h_nxt = h_cnt + 12'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Pixel after the one being presented; its sync state goes out early
        // because the encoders register the control code one strobe late.
        h_succ = h_nxt + 12'd1;
        v_succ = v_nxt;
        if ({1'b0, h_nxt} == H_LAST) begin
            h_succ = '0;
            v_succ = ({1'b0, v_nxt} == V_LAST) ? 12'd0 : v_nxt + 12'd1;
        end

        pix_active_nxt = (state_nxt == ST_RUN) && in_active(h_nxt, v_nxt);
        ctl_nxt        = (state_nxt == ST_RUN) ? ctl_code(h_succ, v_succ) : CTL_IDLE;
    end

    // Pixel divider, strobe and all registered encoder-facing outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            div_cnt          <= '0;
            h_cnt            <= '0;
            v_cnt            <= '0;
            tmds_enable      <= 1'b0;
            tmds_data_enable <= 1'b0;
            tmds_control     <= CTL_IDLE;
            rgb_q            <= '0;
            pix_x            <= '0;
            pix_y            <= '0;
            frame_start      <= 1'b0;
        end else begin
            div_cnt     <= tick ? '0 : div_cnt + 1'b1;
            tmds_enable <= tick;
            frame_start <= frame_new;
            if (tick) begin
                h_cnt            <= h_nxt;
                v_cnt            <= v_nxt;
                pix_x            <= h_nxt;
                pix_y            <= v_nxt;
                tmds_data_enable <= pix_active_nxt;
                tmds_control     <= ctl_nxt;
                rgb_q            <= (s_pixel_ready && s_pixel_valid) ? s_pixel_data : 24'd0;
            end
        end
    end

    // Sticky underflow flag; a new underflow beats a simultaneous clear.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            underflow <= 1'b0;
        end else if (s_pixel_ready && !s_pixel_valid) begin
            underflow <= 1'b1;
        end else if (underflow_clear) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ibis_dvi_timing_ctrl.sv
// Self-checking bench for ibis_dvi_timing_ctrl on an 8x5 raster. The reference
// model tracks the presented pixel as a strobe index within the frame and
// derives coordinates, sync and data-enable from plain arithmetic.
module tb_ibis_dvi_timing_ctrl;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct {
        logic        de;
        logic [1:0]  ctl;
        logic [23:0] rgb;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        busy;
        logic        en;
        logic        uf;
    } exp_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        run;
    logic [23:0] s_pixel_data;
    logic        s_pixel_valid;
    logic        underflow_clear;

    logic        s_pixel_ready, tmds_enable, tmds_data_enable, frame_start, busy, underflow;
    logic [1:0]  tmds_control;
    logic [7:0]  tmds_r, tmds_g, tmds_b;
    logic [11:0] pix_x, pix_y;

    logic        d3_ready, d3_en, d3_de, d3_fs, d3_busy, d3_uf;
    logic [1:0]  d3_ctl;
    logic [7:0]  d3_r, d3_g, d3_b;
    logic [11:0] d3_x, d3_y;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: presented pixel as frame strobe index.
    bit m_busy;
    int m_f;
    bit m_uf;

    always #5 aclk = ~aclk;

    ibis_dvi_timing_ctrl #(
        .PIX_DIV(1), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .run(run),
        .s_pixel_data(s_pixel_data), .s_pixel_valid(s_pixel_valid),
        .s_pixel_ready(s_pixel_ready), .tmds_enable(tmds_enable),
        .tmds_data_enable(tmds_data_enable), .tmds_control(tmds_control),
        .tmds_r(tmds_r), .tmds_g(tmds_g), .tmds_b(tmds_b),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .busy(busy), .underflow(underflow), .underflow_clear(underflow_clear)
    );

    ibis_dvi_timing_ctrl #(
        .PIX_DIV(3), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(0)
    ) dut3 (
        .aclk(aclk), .aresetn(aresetn), .run(run),
        .s_pixel_data(s_pixel_data), .s_pixel_valid(s_pixel_valid),
        .s_pixel_ready(d3_ready), .tmds_enable(d3_en),
        .tmds_data_enable(d3_de), .tmds_control(d3_ctl),
        .tmds_r(d3_r), .tmds_g(d3_g), .tmds_b(d3_b),
        .pix_x(d3_x), .pix_y(d3_y), .frame_start(d3_fs),
        .busy(d3_busy), .underflow(d3_uf), .underflow_clear(underflow_clear)
    );

    function automatic bit m_active(input int f);
        return ((f % HT) < HA) && ((f / HT) < VA);
    endfunction

    // Control code shown with pixel f is the sync state of pixel f+1.
    function automatic logic [1:0] m_ctl(input int f);
        int s, sh, sv;
        bit hs, vs;
        s  = (f + 1) % FT;
        sh = s % HT;
        sv = s / HT;
        hs = (sh >= HA + HF) && (sh < HA + HF + HS);
        vs = (sv >= VA + VF) && (sv < VA + VF + VS);
        return {~vs, ~hs};
    endfunction

    // Frame index presented after the next strobe, or -1 for idle.
    function automatic int m_peek(input bit run_v);
        if (!m_busy || m_f == FT - 1) return run_v ? 0 : -1;
        return m_f + 1;
    endfunction

    function automatic logic [23:0] pix_word(input int idx);
        logic [7:0] i8;
        i8 = 8'(idx);
        return {i8, ~i8, i8 + 8'd1};
    endfunction

    // Apply inputs at the falling edge, step one clock, return model prediction.
    task automatic drive_cycle(input bit run_v, input bit valid_v, input bit clr_v,
                               input logic [23:0] data_v, output exp_t e,
                               output bit rdy_obs, output bit rdy_exp);
        int nf;
        bit act;
        run             = run_v;
        s_pixel_valid   = valid_v;
        underflow_clear = clr_v;
        s_pixel_data    = data_v;
        nf      = m_peek(run_v);
        act     = (nf >= 0) && m_active(nf);
        rdy_exp = act;
        #1 rdy_obs = s_pixel_ready;
        @(posedge aclk);
        if (act && !valid_v) m_uf = 1'b1;
        else if (clr_v)      m_uf = 1'b0;
        m_busy = (nf >= 0);
        m_f    = m_busy ? nf : 0;
        e.busy = m_busy;
        e.x    = m_busy ? 12'(nf % HT) : 12'd0;
        e.y    = m_busy ? 12'(nf / HT) : 12'd0;
        e.de   = act;
        e.rgb  = (act && valid_v) ? data_v : 24'd0;
        e.fs   = (nf == 0);
        e.ctl  = m_busy ? m_ctl(nf) : 2'b11;
        e.en   = 1'b1;
        e.uf   = m_uf;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        exp_t e;
        bit ro, re;
        aresetn = 1'b0; run = 1'b1; s_pixel_valid = 1'b1;
        s_pixel_data = 24'hABCDEF; underflow_clear = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        n_checks++; if (tmds_control !== 2'b11) $display("FAIL reset_ctl got %b want 11", tmds_control); else n_pass++;
        n_checks++; if ({tmds_enable, tmds_data_enable, frame_start, busy, underflow} !== 5'b0)
            $display("FAIL reset_flags got en/de/fs/busy/uf=%b want 00000",
                     {tmds_enable, tmds_data_enable, frame_start, busy, underflow}); else n_pass++;
        n_checks++; if ({tmds_r, tmds_g, tmds_b, pix_x, pix_y} !== 48'd0)
            $display("FAIL reset_data got rgb=%h x=%0d y=%0d want 0", {tmds_r, tmds_g, tmds_b}, pix_x, pix_y); else n_pass++;
        n_checks++; if (s_pixel_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", s_pixel_ready); else n_pass++;
        run = 1'b0; s_pixel_valid = 1'b0;
        aresetn = 1'b1;
        m_busy = 1'b0; m_f = 0; m_uf = 1'b0;
        for (int i = 0; i < 50; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 24'($urandom), e, ro, re);
            n_checks++; if (tmds_control !== 2'b11) $display("FAIL idle_ctl cyc %0d got %b want 11", i, tmds_control); else n_pass++;
            n_checks++; if (tmds_data_enable !== 1'b0) $display("FAIL idle_de cyc %0d got %b want 0", i, tmds_data_enable); else n_pass++;
            n_checks++; if (ro !== 1'b0) $display("FAIL idle_ready cyc %0d got %b want 0", i, ro); else n_pass++;
            n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy cyc %0d got %b want 0", i, busy); else n_pass++;
            n_checks++; if (tmds_enable !== 1'b1) $display("FAIL idle_enable cyc %0d got %b want 1", i, tmds_enable); else n_pass++;
        end
    endtask

    task automatic test_frames();
        exp_t e;
        bit ro, re;
        int src, de_cnt, fs_cnt, fs_at1;
        src = 0; de_cnt = 0; fs_cnt = 0; fs_at1 = -1;
        for (int i = 0; i < 2 * FT; i++) begin
            drive_cycle(1'b1, 1'b1, 1'b0, pix_word(src), e, ro, re);
            if (ro) src++;
            if (tmds_data_enable === 1'b1) de_cnt++;
            if (frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 2) fs_at1 = i;
            end
            n_checks++; if (ro !== re) $display("FAIL frames_ready cyc %0d got %b want %b", i, ro, re); else n_pass++;
            n_checks++; if (tmds_data_enable !== e.de) $display("FAIL frames_de cyc %0d got %b want %b", i, tmds_data_enable, e.de); else n_pass++;
            n_checks++; if (tmds_control !== e.ctl) $display("FAIL frames_ctl cyc %0d got %b want %b", i, tmds_control, e.ctl); else n_pass++;
            n_checks++; if ({tmds_r, tmds_g, tmds_b} !== e.rgb) $display("FAIL frames_rgb cyc %0d got %h want %h", i, {tmds_r, tmds_g, tmds_b}, e.rgb); else n_pass++;
            n_checks++; if (pix_x !== e.x || pix_y !== e.y) $display("FAIL frames_xy cyc %0d got %0d,%0d want %0d,%0d", i, pix_x, pix_y, e.x, e.y); else n_pass++;
            n_checks++; if (frame_start !== e.fs || busy !== e.busy) $display("FAIL frames_fs_busy cyc %0d got %b%b want %b%b", i, frame_start, busy, e.fs, e.busy); else n_pass++;
        end
        n_checks++; if (de_cnt != 2 * HA * VA) $display("FAIL frames_de_count got %0d want %0d", de_cnt, 2 * HA * VA); else n_pass++;
        n_checks++; if (src != 2 * HA * VA) $display("FAIL frames_consumed got %0d want %0d", src, 2 * HA * VA); else n_pass++;
        n_checks++; if (fs_cnt != 2 || fs_at1 != FT) $display("FAIL frames_fs_period got count %0d at %0d want 2 at %0d", fs_cnt, fs_at1, FT); else n_pass++;
    endtask

    task automatic test_underflow();
        exp_t e;
        bit ro, re;
        int guard;
        guard = 0;
        while (!(m_busy && m_peek(1'b1) == 2) && guard < 100) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 24'($urandom), e, ro, re);
            guard++;
        end
        n_checks++; if (guard >= 100) $display("FAIL uflow_reach got %0d cycles want <100", guard); else n_pass++;
        drive_cycle(1'b1, 1'b0, 1'b0, 24'h123456, e, ro, re);
        n_checks++; if (pix_x !== 12'd2 || pix_y !== 12'd0) $display("FAIL uflow_xy got %0d,%0d want 2,0", pix_x, pix_y); else n_pass++;
        n_checks++; if (tmds_data_enable !== 1'b1) $display("FAIL uflow_de got %b want 1", tmds_data_enable); else n_pass++;
        n_checks++; if ({tmds_r, tmds_g, tmds_b} !== 24'd0) $display("FAIL uflow_rgb got %h want 0", {tmds_r, tmds_g, tmds_b}); else n_pass++;
        n_checks++; if (underflow !== 1'b1) $display("FAIL uflow_set got %b want 1", underflow); else n_pass++;
        // pixel (3,0): new underflow together with clear
        drive_cycle(1'b1, 1'b0, 1'b1, 24'h654321, e, ro, re);
        n_checks++; if (underflow !== 1'b1) $display("FAIL uflow_set_wins got %b want 1", underflow); else n_pass++;
        // pixel (4,0) is blanking: clear alone
        drive_cycle(1'b1, 1'b1, 1'b1, 24'h0F0F0F, e, ro, re);
        n_checks++; if (underflow !== 1'b0) $display("FAIL uflow_clear got %b want 0", underflow); else n_pass++;
        underflow_clear = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        bit ro, re, rv, vv, cv;
        for (int i = 0; i < 200; i++) begin
            rv = ($urandom_range(0, 19) != 0);
            vv = ($urandom_range(0, 3) != 0);
            cv = ($urandom_range(0, 9) == 0);
            drive_cycle(rv, vv, cv, 24'($urandom), e, ro, re);
            n_checks++; if (ro !== re) $display("FAIL rand_ready cyc %0d got %b want %b", i, ro, re); else n_pass++;
            n_checks++; if (tmds_data_enable !== e.de) $display("FAIL rand_de cyc %0d got %b want %b", i, tmds_data_enable, e.de); else n_pass++;
            n_checks++; if (tmds_control !== e.ctl) $display("FAIL rand_ctl cyc %0d got %b want %b", i, tmds_control, e.ctl); else n_pass++;
            n_checks++; if ({tmds_r, tmds_g, tmds_b} !== e.rgb) $display("FAIL rand_rgb cyc %0d got %h want %h", i, {tmds_r, tmds_g, tmds_b}, e.rgb); else n_pass++;
            n_checks++; if (pix_x !== e.x || pix_y !== e.y) $display("FAIL rand_xy cyc %0d got %0d,%0d want %0d,%0d", i, pix_x, pix_y, e.x, e.y); else n_pass++;
            n_checks++; if (frame_start !== e.fs || busy !== e.busy) $display("FAIL rand_fs_busy cyc %0d got %b%b want %b%b", i, frame_start, busy, e.fs, e.busy); else n_pass++;
            n_checks++; if (underflow !== e.uf) $display("FAIL rand_uflow cyc %0d got %b want %b", i, underflow, e.uf); else n_pass++;
        end
        underflow_clear = 1'b0;
    endtask

    task automatic test_stop();
        exp_t e;
        bit ro, re;
        int guard;
        guard = 0;
        while (!(m_busy && m_f == HT + 3) && guard < 100) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 24'($urandom), e, ro, re);
            guard++;
        end
        n_checks++; if (guard >= 100) $display("FAIL stop_reach got %0d cycles want <100", guard); else n_pass++;
        for (int i = 1; i <= 30; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 24'($urandom), e, ro, re);
            n_checks++; if (busy !== e.busy || pix_x !== e.x || pix_y !== e.y)
                $display("FAIL stop_track cyc %0d got busy=%b %0d,%0d want busy=%b %0d,%0d", i, busy, pix_x, pix_y, e.busy, e.x, e.y); else n_pass++;
            if (i == FT - 1 - (HT + 3)) begin
                n_checks++; if (busy !== 1'b1 || pix_x !== 12'd7 || pix_y !== 12'd4)
                    $display("FAIL stop_last got busy=%b %0d,%0d want busy=1 7,4", busy, pix_x, pix_y); else n_pass++;
            end
        end
        n_checks++; if (busy !== 1'b0 || tmds_control !== 2'b11) $display("FAIL stop_idle got busy=%b ctl=%b want 0 11", busy, tmds_control); else n_pass++;
    endtask

    task automatic test_reset_midline();
        exp_t e;
        bit ro, re;
        int guard;
        guard = 0;
        while (!(m_busy && m_f == HT + 2) && guard < 100) begin
            drive_cycle(1'b1, 1'b1, 1'b0, 24'($urandom), e, ro, re);
            guard++;
        end
        n_checks++; if (guard >= 100) $display("FAIL rstmid_reach got %0d cycles want <100", guard); else n_pass++;
        aresetn = 1'b0; run = 1'b1; s_pixel_valid = 1'b1;
        #1;
        n_checks++; if (s_pixel_ready !== 1'b0) $display("FAIL rstmid_ready got %b want 0", s_pixel_ready); else n_pass++;
        @(posedge aclk);
        @(negedge aclk);
        n_checks++; if ({tmds_enable, tmds_data_enable, frame_start, busy, underflow, tmds_control} !== 7'b0000011)
            $display("FAIL rstmid_flags got %b want 0000011",
                     {tmds_enable, tmds_data_enable, frame_start, busy, underflow, tmds_control}); else n_pass++;
        n_checks++; if ({tmds_r, tmds_g, tmds_b, pix_x, pix_y} !== 48'd0)
            $display("FAIL rstmid_data got rgb=%h x=%0d y=%0d want 0", {tmds_r, tmds_g, tmds_b}, pix_x, pix_y); else n_pass++;
        aresetn = 1'b1;
        m_busy = 1'b0; m_f = 0; m_uf = 1'b0;
        drive_cycle(1'b1, 1'b1, 1'b0, 24'h00AA55, e, ro, re);
        n_checks++; if (frame_start !== 1'b1 || pix_x !== 12'd0 || pix_y !== 12'd0)
            $display("FAIL rstmid_restart got fs=%b %0d,%0d want fs=1 0,0", frame_start, pix_x, pix_y); else n_pass++;
    endtask

    task automatic test_div3();
        int j, f;
        bit exp_en, exp_fs, exp_de;
        logic [11:0] ex, ey;
        aresetn = 1'b0; run = 1'b1; s_pixel_valid = 1'b1; underflow_clear = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int c = 1; c <= 3 * FT + 6; c++) begin
            @(posedge aclk);
            @(negedge aclk);
            exp_en = (c % 3 == 0);
            exp_fs = (c >= 3) && ((c - 3) % (3 * FT) == 0);
            if (c >= 3) begin
                j = c / 3 - 1;
                f = j % FT;
                ex = 12'(f % HT); ey = 12'(f / HT); exp_de = m_active(f);
            end else begin
                ex = 12'd0; ey = 12'd0; exp_de = 1'b0;
            end
            n_checks++; if (d3_en !== exp_en) $display("FAIL div3_enable cyc %0d got %b want %b", c, d3_en, exp_en); else n_pass++;
            n_checks++; if (d3_fs !== exp_fs) $display("FAIL div3_fs cyc %0d got %b want %b", c, d3_fs, exp_fs); else n_pass++;
            n_checks++; if (d3_x !== ex || d3_y !== ey) $display("FAIL div3_xy cyc %0d got %0d,%0d want %0d,%0d", c, d3_x, d3_y, ex, ey); else n_pass++;
            n_checks++; if (d3_de !== exp_de) $display("FAIL div3_de cyc %0d got %b want %b", c, d3_de, exp_de); else n_pass++;
            n_checks++; if (d3_busy !== (c >= 3)) $display("FAIL div3_busy cyc %0d got %b want %b", c, d3_busy, (c >= 3)); else n_pass++;
        end
    endtask

    initial begin
        aresetn = 1'b0; run = 1'b0; s_pixel_valid = 1'b0;
        s_pixel_data = 24'd0; underflow_clear = 1'b0;
        m_busy = 1'b0; m_f = 0; m_uf = 1'b0;
        @(negedge aclk);
        test_reset();
        test_frames();
        test_underflow();
        test_random();
        test_stop();
        test_reset_midline();
        test_div3();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
